wb_slave_regfile: RTL and testbench
===================================

Name: wb_slave_regfile

Overview:
- Wishbone B4 pipelined slave with a byte-lane-writable register file of REGISTER_NUM words.
- Register 0 is a read-only ID register; all others are read/write.
- Sits directly upstream of the bus-protocol assertion monitor: its ack_o/err_o/stall_o/dat_o are the signals that monitor checks.
- Supports configurable wait states and one outstanding request.

Parameters:
- ADDR_WIDTH, 16, width of adr_i; word address, not byte address.
- DATA_WIDTH, 32, data bus width.
- GRANULE, 8, bits per byte lane.
- REGISTER_NUM, 16, number of registers; valid indices 0..REGISTER_NUM-1.
- WAIT_STATES, 0, extra cycles between acceptance and response; range 0..15.
- ID_VALUE, 32'h5742_0001, constant returned by register 0.
- SEL_WIDTH, DATA_WIDTH/GRANULE, localparam.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- cyc_i  in  1  bus cycle valid.
- stb_i  in  1  request strobe.
- we_i  in  1  1 = write, 0 = read.
- adr_i  in  ADDR_WIDTH  register index.
- dat_i  in  DATA_WIDTH  write data.
- sel_i  in  SEL_WIDTH  byte-lane enables.
- dat_o  out  DATA_WIDTH  read data, valid with ack_o.
- ack_o  out  1  successful completion.
- err_o  out  1  error completion.
- stall_o  out  1  slave cannot accept a request this cycle.

Behaviour:
- Reset (async assert, synchronous release on clk_i):
  - ack_o, err_o, stall_o = 0; dat_o = 0.
  - Registers 1..REGISTER_NUM-1 = 0.
  - FSM = IDLE; wait counter = 0.
- Acceptance: cyc_i & stb_i & !stall_o at a rising edge. At that edge, latch we_i, adr_i, dat_i and sel_i into request registers.
- FSM states:
  - IDLE: stall_o = 0. On acceptance, go to WAIT if WAIT_STATES > 0, else RESP.
  - WAIT: stall_o = 1. Counter loads WAIT_STATES-1 on entry and decrements each cycle. When counter = 0, go to RESP.
  - RESP: ack_o or err_o high for exactly one cycle; stall_o = 0. If a new acceptance occurs in this cycle, go to WAIT/RESP as from IDLE; otherwise go to IDLE.
- Latency:
  - Response is driven WAIT_STATES+1 cycles after the acceptance edge.
  - With WAIT_STATES = 0, stall_o stays 0 and back-to-back requests get ack every cycle (full pipeline).
- Error conditions; the response is err_o instead of ack_o:
  - Index >= REGISTER_NUM.
  - Write to index 0.
- ack_o and err_o are never both high.
- Writes:
  - Committed at the edge that ends RESP, only when ack is issued.
  - Byte lane k is updated from dat_i[k*GRANULE +: GRANULE] iff the latched sel_i[k] = 1.
  - sel_i = 0 still acks with no change.
- Reads:
  - dat_o = register value, or ID_VALUE for index 0, during the ack cycle.
  - dat_o = 0 during an err cycle.
  - dat_o holds its last value when no response is being driven.
  - A read issued in the cycle after a write to the same index returns the new value.
- Abort: if cyc_i = 0 while in WAIT or RESP:
  - The outstanding request is dropped: no ack/err, no write commit.
  - FSM goes to IDLE next cycle; ack_o/err_o are forced 0 while cyc_i = 0.
- stb_i while cyc_i = 0 is ignored.
- Reset mid-transaction: outputs clear immediately, the request is discarded, and the register file clears.

Test Plan:
- Reset: assert rst_i mid-WAIT with WAIT_STATES = 2 -> ack_o = err_o = stall_o = 0 and dat_o = 0 in the same cycle; read of reg 3 after release returns 0.
- Write/read, WAIT_STATES = 0: write 0xDEADBEEF to reg 5 with sel_i = 4'hF, then read reg 5 -> ack_o one cycle after each strobe; read dat_o = 0xDEADBEEF; stall_o never 1.
- Byte lanes: reg 2 = 0xDEADBEEF; write 0x11223344 with sel_i = 4'b0101 -> reg 2 reads 0xDE22BE44.
- Errors: read reg 16 and write reg 0 -> err_o one cycle each, ack_o = 0, dat_o = 0; read reg 0 -> ack_o with dat_o = 0x57420001.
- Wait states, WAIT_STATES = 3: strobe accepted at cycle t -> stall_o = 1 for cycles t+1..t+3; ack_o at t+4; a second strobe held through the stall is accepted at t+4 and acked at t+8.
- Abort: WAIT_STATES = 2, write 0xAAAA5555 to reg 7, drop cyc_i at t+1 -> no ack/err; reg 7 still reads its prior value 0.

Source files
------------

// File: rtl/wb_slave_regfile_if.sv
// rtl/wb_slave_regfile_if.sv - Wishbone B4 pipelined bus bundle for the register file slave
interface wb_slave_regfile_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int GRANULE    = 8
);
  localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;

  logic                  cyc_i;
  logic                  stb_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] adr_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [SEL_WIDTH-1:0]  sel_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  ack_o;
  logic                  err_o;
  logic                  stall_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    input  dat_o, ack_o, err_o, stall_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    output dat_o, ack_o, err_o, stall_o
  );
endinterface

// File: rtl/wb_slave_regfile.sv
// rtl/wb_slave_regfile.sv - Wishbone pipelined slave with byte-lane writable register file
// Register 0 is a read-only ID; one request outstanding, optional wait states.
module wb_slave_regfile #(
  parameter int                     ADDR_WIDTH   = 16,
  parameter int                     DATA_WIDTH   = 32,
  parameter int                     GRANULE      = 8,
  parameter int                     REGISTER_NUM = 16,
  parameter int                     WAIT_STATES  = 0,
  parameter logic [DATA_WIDTH-1:0]  ID_VALUE     = 32'h5742_0001
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  wb_slave_regfile_if.slave     bus
);
  localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;
  localparam int IDX_W     = (REGISTER_NUM > 1) ? $clog2(REGISTER_NUM) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state, state_nx;
  logic [3:0]            wait_cnt;
  logic                  req_we;
  logic                  req_err;
  logic [IDX_W-1:0]      req_idx;
  logic [DATA_WIDTH-1:0] req_dat;
  logic [SEL_WIDTH-1:0]  req_sel;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] dat_nx;
  logic [DATA_WIDTH-1:0] regs [REGISTER_NUM];
  logic                  stall;
  logic                  accept;
  logic                  bad_idx;
  logic                  resp_live;
  logic                  ack;
  logic                  err;

  assign stall     = (state == S_WAIT);
  assign accept    = bus.cyc_i & bus.stb_i & ~stall;
  assign bad_idx   = (bus.adr_i >= ADDR_WIDTH'(REGISTER_NUM));
  // Dropping cyc_i kills the response in the same cycle it would be driven.
  assign resp_live = (state == S_RESP) & bus.cyc_i;
  assign ack       = resp_live & ~req_err;
  assign err       = resp_live & req_err;

  assign bus.stall_o = stall;
  assign bus.ack_o   = ack;
  assign bus.err_o   = err;
  assign bus.dat_o   = dat_nx;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nx = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        if (!bus.cyc_i)          state_nx = S_IDLE;
        else if (wait_cnt == '0) state_nx = S_RESP;
      end
      S_RESP: begin
        if (accept) state_nx = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        else        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      if (accept)
        wait_cnt <= 4'(WAIT_STATES - 1);
      else if (stall && wait_cnt != '0)
        wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_we  <= 1'b0;
      req_err <= 1'b0;
      req_idx <= '0;
      req_dat <= '0;
      req_sel <= '0;
    end else if (accept) begin
      req_we  <= bus.we_i;
      req_err <= bad_idx | (bus.we_i & (bus.adr_i == '0));
      req_idx <= bus.adr_i[IDX_W-1:0];
      req_dat <= bus.dat_i;
      req_sel <= bus.sel_i;
    end
  end

  always_comb begin
    rd_data = ID_VALUE;
    if (req_idx != '0) rd_data = regs[req_idx];
  end

  // Read data and error zeros are registered so dat_o holds between responses.
  always_comb begin
    dat_nx = dat_q;
    if (resp_live) begin
      if (req_err)      dat_nx = '0;
      else if (!req_we) dat_nx = rd_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) dat_q <= '0;
    else       dat_q <= dat_nx;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < REGISTER_NUM; i++) regs[i] <= '0;
    end else if (ack && req_we) begin
      for (int k = 0; k < SEL_WIDTH; k++) begin
        if (req_sel[k]) regs[req_idx][k*GRANULE +: GRANULE] <= req_dat[k*GRANULE +: GRANULE];
      end
    end
  end
endmodule

// File: tb/tb_wb_slave_regfile.sv
// tb/tb_wb_slave_regfile.sv - directed vector bench for wb_slave_regfile
module tb_wb_slave_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_slave_regfile_if bus0 ();
  wb_slave_regfile_if bus2 ();
  wb_slave_regfile_if bus3 ();

  wb_slave_regfile #(.WAIT_STATES(0)) u0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
  wb_slave_regfile #(.WAIT_STATES(2)) u2 (.clk_i(clk), .rst_i(rst), .bus(bus2));
  wb_slave_regfile #(.WAIT_STATES(3)) u3 (.clk_i(clk), .rst_i(rst), .bus(bus3));

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_ack;
    logic        exp_err;
    logic        chk_dat;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic xfer0(input int i, input vec_t v);
    @(negedge clk);
    bus0.cyc_i = 1'b1; bus0.stb_i = 1'b1; bus0.we_i = v.we;
    bus0.adr_i = v.adr; bus0.dat_i = v.dat; bus0.sel_i = v.sel;
    check($sformatf("v%0d_stall", i), 32'(bus0.stall_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("v%0d_ack", i), 32'(bus0.ack_o), 32'(v.exp_ack));
    check($sformatf("v%0d_err", i), 32'(bus0.err_o), 32'(v.exp_err));
    if (v.chk_dat) check($sformatf("v%0d_dat", i), bus0.dat_o, v.exp_dat);
    bus0.stb_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus0.cyc_i = 1'b0;
  endtask

  task automatic xfer2(input string name, input logic we, input logic [15:0] adr,
                       input logic [31:0] dat, output logic ack, output logic err,
                       output logic [31:0] rdat);
    bit done = 0;
    ack = 0; err = 0; rdat = '0;
    @(negedge clk);
    bus2.cyc_i = 1'b1; bus2.stb_i = 1'b1; bus2.we_i = we;
    bus2.adr_i = adr; bus2.dat_i = dat; bus2.sel_i = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bus2.stb_i = 1'b0;
    for (int n = 0; n < 12 && !done; n++) begin
      if (bus2.ack_o || bus2.err_o) begin
        ack = bus2.ack_o; err = bus2.err_o; rdat = bus2.dat_o; done = 1;
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    if (!done) check({name, "_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus2.cyc_i = 1'b0;
  endtask

  initial begin
    logic        a, e;
    logic [31:0] d;

    bus0.cyc_i = 0; bus0.stb_i = 0; bus0.we_i = 0; bus0.adr_i = 0; bus0.dat_i = 0; bus0.sel_i = 0;
    bus2.cyc_i = 0; bus2.stb_i = 0; bus2.we_i = 0; bus2.adr_i = 0; bus2.dat_i = 0; bus2.sel_i = 0;
    bus3.cyc_i = 0; bus3.stb_i = 0; bus3.we_i = 0; bus3.adr_i = 0; bus3.dat_i = 0; bus3.sel_i = 0;

    //           we  adr       dat           sel    ack err chk exp
    vecs[0]  = '{0, 16'd3,    32'h0,        4'hF,  1,  0,  1,  32'h0};
    vecs[1]  = '{1, 16'd5,    32'hDEADBEEF, 4'hF,  1,  0,  0,  32'h0};
    vecs[2]  = '{0, 16'd5,    32'h0,        4'hF,  1,  0,  1,  32'hDEADBEEF};
    vecs[3]  = '{1, 16'd2,    32'hDEADBEEF, 4'hF,  1,  0,  0,  32'h0};
    vecs[4]  = '{1, 16'd2,    32'h11223344, 4'h5,  1,  0,  0,  32'h0};
    vecs[5]  = '{0, 16'd2,    32'h0,        4'hF,  1,  0,  1,  32'hDE22BE44};
    vecs[6]  = '{0, 16'd16,   32'h0,        4'hF,  0,  1,  1,  32'h0};
    vecs[7]  = '{1, 16'd0,    32'h12345678, 4'hF,  0,  1,  1,  32'h0};
    vecs[8]  = '{0, 16'd0,    32'h0,        4'hF,  1,  0,  1,  32'h57420001};
    vecs[9]  = '{1, 16'd4,    32'hCAFEF00D, 4'h0,  1,  0,  0,  32'h0};
    vecs[10] = '{0, 16'd4,    32'h0,        4'hF,  1,  0,  1,  32'h0};
    vecs[11] = '{1, 16'd15,   32'hA5A5A5A5, 4'h8,  1,  0,  0,  32'h0};
    vecs[12] = '{0, 16'd15,   32'h0,        4'hF,  1,  0,  1,  32'hA5000000};
    vecs[13] = '{0, 16'hFFFF, 32'h0,        4'hF,  0,  1,  1,  32'h0};
    vecs[14] = '{1, 16'd16,   32'h1,        4'hF,  0,  1,  1,  32'h0};
    vecs[15] = '{0, 16'd15,   32'h0,        4'hF,  1,  0,  1,  32'hA5000000};

    repeat (2) @(negedge clk);
    check("rst_ack", 32'(bus0.ack_o), 32'd0);
    check("rst_err", 32'(bus0.err_o), 32'd0);
    check("rst_stall", 32'(bus3.stall_o), 32'd0);
    check("rst_dat", bus2.dat_o, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) xfer0(i, vecs[i]);

    // Back-to-back write then two reads of the same index with no wait states.
    @(negedge clk);
    bus0.cyc_i = 1; bus0.stb_i = 1; bus0.we_i = 1; bus0.adr_i = 16'd9;
    bus0.dat_i = 32'h01020304; bus0.sel_i = 4'hF;
    @(posedge clk); @(negedge clk);
    check("pipe_w_ack", 32'(bus0.ack_o), 32'd1);
    bus0.we_i = 0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("pipe_r%0d_ack", k), 32'(bus0.ack_o), 32'd1);
      check($sformatf("pipe_r%0d_dat", k), bus0.dat_o, 32'h01020304);
      check($sformatf("pipe_r%0d_stall", k), 32'(bus0.stall_o), 32'd0);
    end
    bus0.stb_i = 0;
    @(posedge clk); @(negedge clk);
    check("pipe_idle_ack", 32'(bus0.ack_o), 32'd0);
    check("pipe_hold_dat", bus0.dat_o, 32'h01020304);
    bus0.cyc_i = 0;

    // Three wait states, second strobe held through the stall.
    @(negedge clk);
    bus3.cyc_i = 1; bus3.stb_i = 1; bus3.we_i = 0; bus3.adr_i = 16'd0; bus3.sel_i = 4'hF;
    @(posedge clk);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      check($sformatf("ws3_c%0d_stall", i), 32'(bus3.stall_o),
            32'((i >= 1 && i <= 3) || (i >= 5 && i <= 7)));
      check($sformatf("ws3_c%0d_ack", i), 32'(bus3.ack_o), 32'(i == 4 || i == 8));
      if (i == 4 || i == 8) check($sformatf("ws3_c%0d_dat", i), bus3.dat_o, 32'h57420001);
      if (i == 5) bus3.stb_i = 0;
      @(posedge clk);
    end
    @(negedge clk);
    bus3.cyc_i = 0;

    // Abort during wait states: no response and no commit.
    @(negedge clk);
    bus2.cyc_i = 1; bus2.stb_i = 1; bus2.we_i = 1; bus2.adr_i = 16'd7;
    bus2.dat_i = 32'hAAAA5555; bus2.sel_i = 4'hF;
    @(posedge clk); @(negedge clk);
    check("abort_stall", 32'(bus2.stall_o), 32'd1);
    bus2.cyc_i = 0; bus2.stb_i = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("abort_c%0d_resp", i), 32'(bus2.ack_o | bus2.err_o), 32'd0);
    end
    xfer2("abort_rd", 0, 16'd7, 32'h0, a, e, d);
    check("abort_rd_ack", 32'(a), 32'd1);
    check("abort_rd_dat", d, 32'h0);

    // Reset in the middle of a waited read.
    xfer2("ws2_wr", 1, 16'd3, 32'h12345678, a, e, d);
    check("ws2_wr_ack", 32'(a), 32'd1);
    xfer2("ws2_rd", 0, 16'd3, 32'h0, a, e, d);
    check("ws2_rd_dat", d, 32'h12345678);
    @(negedge clk);
    bus2.cyc_i = 1; bus2.stb_i = 1; bus2.we_i = 0; bus2.adr_i = 16'd3;
    @(posedge clk); @(negedge clk);
    check("mid_stall", 32'(bus2.stall_o), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ack", 32'(bus2.ack_o), 32'd0);
    check("mid_rst_err", 32'(bus2.err_o), 32'd0);
    check("mid_rst_stall", 32'(bus2.stall_o), 32'd0);
    check("mid_rst_dat", bus2.dat_o, 32'd0);
    bus2.cyc_i = 0; bus2.stb_i = 0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    xfer2("post_rst_rd", 0, 16'd3, 32'h0, a, e, d);
    check("post_rst_ack", 32'(a), 32'd1);
    check("post_rst_dat", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
